// File: rtl/p405s_watchdogfitcontrol.sv
// p405s_watchdogfitcontrol
//   Watchdog / fixed-interval timer (FIT) event sequencer for the timer unit.
//   The selected time-base tap bits are edge-detected. Each watchdog edge
//   moves the watchdog one step forward: ENW, then WIS, then a timed reset
//   request. Each FIT edge sets FIS. Software clears status bits by writing
//   ones with mtSPR.
//
//   Bit order: the architectural registers number bit 0 as the MSB. The
//   vectors here are declared descending, so bit 0 sits at the left end.
//   A literal such as 5'b10000 then reads exactly as the architectural
//   string ENW,WIS,WRS,WRS,FIS.
//     timerControlL2[9:8] WP   [7:6] WRC  [5] WIE  [4] DIE (unused)
//                   [3:2] FP   [1]   FIE  [0] ARE (unused)
//     tsrL2 / EXE_sprDataBus: [4] ENW  [3] WIS  [2:1] WRS  [0] FIS
//
// Ports
//   CB              core clock, all state changes on its rising edge
//   resetCore       synchronous active-high reset
//   timerControlL2  TCR contents (see bit map above)
//   wdTap, fitTap   time-base tap bits, selected by WP / FP
//   EXE_sprDataBus  mtSPR write data (write-one-to-clear mask)
//   PCL_mtSPR, PCL_sprHold, tsrDcd  SPR write qualification
//   tsrL2           timer status register
//   wdInt, fitInt   interrupt requests (status AND enable)
//   wdResetReq      reset type request, nonzero only while in RST
//   wdStateDbg      current watchdog state (0 = IDLE, 1 = RST)
//
// Handshake: there is no valid/ready traffic. An SPR write takes effect
// in any cycle where PCL_mtSPR & tsrDcd & ~PCL_sprHold is true. A held
// write has no effect at all.
module p405s_watchdogfitcontrol #(
  parameter int unsigned RST_CYCLES = 16
) (
  input  logic       CB,
  input  logic       resetCore,
  input  logic [9:0] timerControlL2,
  input  logic [3:0] wdTap,
  input  logic [3:0] fitTap,
  input  logic [4:0] EXE_sprDataBus,
  input  logic       PCL_mtSPR,
  input  logic       PCL_sprHold,
  input  logic       tsrDcd,
  output logic [4:0] tsrL2,
  output logic       wdInt,
  output logic       fitInt,
  output logic [1:0] wdResetReq,
  output logic       wdStateDbg
);

  typedef enum logic {IDLE = 1'b0, RST = 1'b1} wdState_t;

  localparam int ENW    = 4;
  localparam int WIS    = 3;
  localparam int FIS    = 0;
  localparam logic [7:0] CNT_LOAD = 8'(RST_CYCLES - 1);

  wdState_t   state, stateNext;
  logic [7:0] counter, counterNext;
  logic [1:0] rstTypeQ, rstTypeNext;
  logic [4:0] tsrNext, tsrClr;
  logic [3:0] wdTapQ, fitTapQ;

  logic [1:0] wp, wrc, fp;
  logic       wie, fie, clrEn, wdEvent, fitEvent;
  logic       unusedTcr;

  assign wp  = timerControlL2[9:8];
  assign wrc = timerControlL2[7:6];
  assign wie = timerControlL2[5];
  assign fp  = timerControlL2[3:2];
  assign fie = timerControlL2[1];
  assign unusedTcr = timerControlL2[4] ^ timerControlL2[0];

  // The edge is taken on the currently selected bit against its own
  // previous value. A WP/FP change therefore never produces a false edge.
  assign wdEvent  = wdTap[wp] & ~wdTapQ[wp];
  assign fitEvent = fitTap[fp] & ~fitTapQ[fp];
  assign clrEn    = PCL_mtSPR & tsrDcd & ~PCL_sprHold;

  // State register
  always_ff @(posedge CB) begin
    if (resetCore) begin
      state    <= IDLE;
      tsrL2    <= '0;
      counter  <= '0;
      rstTypeQ <= '0;
      wdTapQ   <= wdTap;
      fitTapQ  <= fitTap;
    end else begin
      state    <= stateNext;
      tsrL2    <= tsrNext;
      counter  <= counterNext;
      rstTypeQ <= rstTypeNext;
      wdTapQ   <= wdTap;
      fitTapQ  <= fitTap;
    end
  end

  // Next state. The software clear is applied first and the events are
  // evaluated on the cleared value, so a set from an event wins over a
  // clear of the same bit.
  always_comb begin
    tsrClr      = tsrL2 & ~(clrEn ? EXE_sprDataBus : 5'b00000);
    tsrNext     = tsrClr;
    stateNext   = state;
    counterNext = counter;
    rstTypeNext = rstTypeQ;
    if (fitEvent) tsrNext[FIS] = 1'b1;
    case (state)
      IDLE: begin
        if (wdEvent) begin
          if (!tsrClr[ENW]) begin
            tsrNext[ENW] = 1'b1;
          end else if (!tsrClr[WIS]) begin
            tsrNext[WIS] = 1'b1;
          end else if (wrc != 2'b00) begin
            tsrNext[2:1] = wrc;
            rstTypeNext  = wrc;
            counterNext  = CNT_LOAD;
            stateNext    = RST;
          end
        end
      end
      RST: begin
        // Watchdog edges are ignored here. The pulse length depends only on
        // the counter, and the request value comes from rstTypeQ. Clearing
        // WRS in software therefore does not change the pulse already running.
        if (counter == 8'd0) stateNext = IDLE;
        else                 counterNext = counter - 8'd1;
      end
    endcase
  end

  // Outputs
  always_comb begin
    wdInt      = tsrL2[WIS] & wie;
    fitInt     = tsrL2[FIS] & fie;
    wdResetReq = (state == RST) ? rstTypeQ : 2'b00;
    wdStateDbg = (state == RST);
  end

endmodule

// File: tb/tb_p405s_watchdogfitcontrol.sv
module tb_p405s_watchdogfitcontrol;

  localparam int RST_CYCLES = 16;

  // ---------------- clock / reset / DUT ----------------
  logic       CB = 1'b0;
  logic       resetCore = 1'b1;
  logic [9:0] timerControlL2 = '0;
  logic [3:0] wdTap = '0, fitTap = '0;
  logic [4:0] EXE_sprDataBus = '0;
  logic       PCL_mtSPR = 1'b0, PCL_sprHold = 1'b0, tsrDcd = 1'b0;
  logic [4:0] tsrL2;
  logic       wdInt, fitInt, wdStateDbg;
  logic [1:0] wdResetReq;

  always #5 CB = ~CB;

  p405s_watchdogfitcontrol #(.RST_CYCLES(RST_CYCLES)) dut (
    .CB(CB), .resetCore(resetCore), .timerControlL2(timerControlL2),
    .wdTap(wdTap), .fitTap(fitTap), .EXE_sprDataBus(EXE_sprDataBus),
    .PCL_mtSPR(PCL_mtSPR), .PCL_sprHold(PCL_sprHold), .tsrDcd(tsrDcd),
    .tsrL2(tsrL2), .wdInt(wdInt), .fitInt(fitInt),
    .wdResetReq(wdResetReq), .wdStateDbg(wdStateDbg)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // The model keeps the architectural status bits as separate flags. The
  // reset pulse is modelled as the number of cycles it still has to run.
  bit       mEnw, mWis, mFis;
  bit [1:0] mWrs, mRstType;
  int       mRstLeft;
  bit [3:0] mPrevWd, mPrevFit;

  task automatic modelStep();
    int  wp, fp;
    bit  we, fe;
    bit [1:0] wrc;
    if (resetCore) begin
      {mEnw, mWis, mFis} = '0;
      mWrs = 0; mRstType = 0; mRstLeft = 0;
    end else begin
      wp  = int'(timerControlL2[9:8]);
      fp  = int'(timerControlL2[3:2]);
      wrc = timerControlL2[7:6];
      we  = wdTap[wp] && !mPrevWd[wp];
      fe  = fitTap[fp] && !mPrevFit[fp];
      if (PCL_mtSPR && tsrDcd && !PCL_sprHold) begin
        if (EXE_sprDataBus[4]) mEnw = 0;
        if (EXE_sprDataBus[3]) mWis = 0;
        if (EXE_sprDataBus[2]) mWrs[1] = 0;
        if (EXE_sprDataBus[1]) mWrs[0] = 0;
        if (EXE_sprDataBus[0]) mFis = 0;
      end
      if (fe) mFis = 1;
      if (mRstLeft > 0) mRstLeft--;
      else if (we) begin
        if (!mEnw)            mEnw = 1;
        else if (!mWis)       mWis = 1;
        else if (wrc != 0) begin
          mWrs = wrc; mRstType = wrc; mRstLeft = RST_CYCLES;
        end
      end
    end
    mPrevWd  = wdTap;
    mPrevFit = fitTap;
  endtask

  // One clock: the model consumes the inputs held across the edge, and the
  // DUT outputs are sampled 2 time units after the edge.
  task automatic cycle();
    modelStep();
    @(posedge CB);
    #2;
    check("m_tsr", int'(tsrL2), int'({mEnw, mWis, mWrs, mFis}));
    check("m_wdInt", int'(wdInt), int'(mWis & timerControlL2[5]));
    check("m_fitInt", int'(fitInt), int'(mFis & timerControlL2[1]));
    check("m_req", int'(wdResetReq), (mRstLeft > 0) ? int'(mRstType) : 0);
    check("m_state", int'(wdStateDbg), int'(mRstLeft > 0));
  endtask

  // ---------------- driver tasks ----------------
  function automatic logic [9:0] mkTcr(logic [1:0] wp, logic [1:0] wrc, logic wie,
                                       logic [1:0] fp, logic fie);
    return {wp, wrc, wie, 1'b0, fp, fie, 1'b0};
  endfunction

  task automatic apply(input logic rst, input logic [9:0] tcr, input logic [3:0] wd,
                       input logic [3:0] fit, input logic clr, input logic hold,
                       input logic [4:0] data);
    resetCore = rst; timerControlL2 = tcr; wdTap = wd; fitTap = fit;
    PCL_mtSPR = clr; tsrDcd = clr; PCL_sprHold = hold; EXE_sprDataBus = data;
    cycle();
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic       rst;
    logic [9:0] tcr;
    logic [3:0] wd;
    logic [4:0] expTsr;
    logic [1:0] expReq;
    logic       expWdInt;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int cnt;
    logic [9:0] t1;

    vecs[0] = '{1'b1, mkTcr(2'b00, 2'b00, 1'b0, 2'b00, 1'b0), 4'b0001, 5'b00000, 2'b00, 1'b0};
    vecs[1] = '{1'b0, mkTcr(2'b00, 2'b00, 1'b0, 2'b00, 1'b0), 4'b0001, 5'b00000, 2'b00, 1'b0};
    t1 = mkTcr(2'b01, 2'b10, 1'b1, 2'b00, 1'b0);
    vecs[2] = '{1'b0, t1, 4'b0001, 5'b00000, 2'b00, 1'b0};
    vecs[3] = '{1'b0, t1, 4'b0011, 5'b10000, 2'b00, 1'b0};
    vecs[4] = '{1'b0, t1, 4'b0001, 5'b10000, 2'b00, 1'b0};
    vecs[5] = '{1'b0, t1, 4'b0011, 5'b11000, 2'b00, 1'b1};
    vecs[6] = '{1'b0, t1, 4'b0001, 5'b11000, 2'b00, 1'b1};
    vecs[7] = '{1'b0, t1, 4'b0011, 5'b11100, 2'b10, 1'b1};

    for (int i = 0; i < 8; i++) begin
      apply(vecs[i].rst, vecs[i].tcr, vecs[i].wd, 4'b0000, 1'b0, 1'b0, 5'b00000);
      check($sformatf("vec%0d_tsr", i), int'(tsrL2), int'(vecs[i].expTsr));
      check($sformatf("vec%0d_req", i), int'(wdResetReq), int'(vecs[i].expReq));
      check($sformatf("vec%0d_wdInt", i), int'(wdInt), int'(vecs[i].expWdInt));
    end

    // Reset pulse length: the entry sample counts as the first cycle.
    cnt = 1;
    for (int i = 0; i < 40; i++) begin
      apply(1'b0, t1, 4'b0011, 4'b0000, 1'b0, 1'b0, 5'b00000);
      if (wdResetReq != 2'b00) cnt++;
      else break;
    end
    check("pulse_len", cnt, RST_CYCLES);
    check("wrs_sticky", int'(tsrL2), int'(5'b11100));

    // Clear all bits, then bring the status to ENW=1.
    apply(1'b0, t1, 4'b0011, 4'b0000, 1'b1, 1'b0, 5'b11111);
    check("clr_all", int'(tsrL2), 0);
    apply(1'b0, t1, 4'b0001, 4'b0000, 1'b0, 1'b0, 5'b00000);
    apply(1'b0, t1, 4'b0011, 4'b0000, 1'b0, 1'b0, 5'b00000);
    check("enw_set", int'(tsrL2), int'(5'b10000));
    // An event and a clear of ENW in the same cycle: ENW is set again, WIS stays 0.
    apply(1'b0, t1, 4'b0001, 4'b0000, 1'b0, 1'b0, 5'b00000);
    apply(1'b0, t1, 4'b0011, 4'b0000, 1'b1, 1'b0, 5'b10000);
    check("clr_vs_evt", int'(tsrL2), int'(5'b10000));
    // The same case with the write held: the clear is blocked and the event advances.
    apply(1'b0, t1, 4'b0001, 4'b0000, 1'b0, 1'b0, 5'b00000);
    apply(1'b0, t1, 4'b0011, 4'b0000, 1'b1, 1'b1, 5'b10000);
    check("held_clr", int'(tsrL2), int'(5'b11000));

    // FIT event, FIT clear, and an FP change onto a tap that is already high.
    t1 = mkTcr(2'b01, 2'b10, 1'b1, 2'b11, 1'b1);
    apply(1'b0, t1, 4'b0011, 4'b0000, 1'b0, 1'b0, 5'b00000);
    apply(1'b0, t1, 4'b0011, 4'b1000, 1'b0, 1'b0, 5'b00000);
    check("fis_set", int'(tsrL2), int'(5'b11001));
    check("fitInt", int'(fitInt), 1);
    apply(1'b0, t1, 4'b0011, 4'b1000, 1'b1, 1'b0, 5'b00001);
    check("fis_clr", int'(tsrL2), int'(5'b11000));
    apply(1'b0, t1, 4'b0011, 4'b1001, 1'b0, 1'b0, 5'b00000);
    apply(1'b0, mkTcr(2'b01, 2'b10, 1'b1, 2'b00, 1'b1), 4'b0011, 4'b1001, 1'b0, 1'b0, 5'b00000);
    check("fp_switch", int'(tsrL2), int'(5'b11000));

    // WRC=00 blocks the reset. WRC=11 then gives a type-11 request, cut short by reset.
    t1 = mkTcr(2'b01, 2'b00, 1'b1, 2'b00, 1'b0);
    apply(1'b0, t1, 4'b0001, 4'b0000, 1'b0, 1'b0, 5'b00000);
    apply(1'b0, t1, 4'b0011, 4'b0000, 1'b0, 1'b0, 5'b00000);
    check("wrc0_tsr", int'(tsrL2), int'(5'b11000));
    check("wrc0_req", int'(wdResetReq), 0);
    t1 = mkTcr(2'b01, 2'b11, 1'b1, 2'b00, 1'b0);
    apply(1'b0, t1, 4'b0001, 4'b0000, 1'b0, 1'b0, 5'b00000);
    apply(1'b0, t1, 4'b0011, 4'b0000, 1'b0, 1'b0, 5'b00000);
    check("wrc3_req", int'(wdResetReq), 3);
    check("wrc3_tsr", int'(tsrL2), int'(5'b11110));
    for (int i = 0; i < 4; i++) apply(1'b0, t1, 4'b0011, 4'b0000, 1'b0, 1'b0, 5'b00000);
    apply(1'b1, t1, 4'b0011, 4'b0000, 1'b0, 1'b0, 5'b00000);
    check("rst_mid_tsr", int'(tsrL2), 0);
    check("rst_mid_req", int'(wdResetReq), 0);
    check("rst_mid_int", int'({wdInt, fitInt}), 0);

    // Enter RST with WRC=01. In RST, a watchdog edge plus a WRS clear leave the pulse length unchanged.
    t1 = mkTcr(2'b01, 2'b01, 1'b1, 2'b00, 1'b0);
    for (int i = 0; i < 3; i++) begin
      apply(1'b0, t1, 4'b0001, 4'b0000, 1'b0, 1'b0, 5'b00000);
      apply(1'b0, t1, 4'b0011, 4'b0000, 1'b0, 1'b0, 5'b00000);
    end
    check("rst2_req", int'(wdResetReq), 1);
    cnt = 1;
    for (int i = 0; i < 40; i++) begin
      if (i == 0)      apply(1'b0, t1, 4'b0001, 4'b0000, 1'b0, 1'b0, 5'b00000);
      else if (i == 1) apply(1'b0, t1, 4'b0011, 4'b0000, 1'b1, 1'b0, 5'b00110);
      else             apply(1'b0, t1, 4'b0011, 4'b0000, 1'b0, 1'b0, 5'b00000);
      if (wdResetReq != 2'b00) cnt++;
      else break;
    end
    check("pulse_len2", cnt, RST_CYCLES);
    check("wrs_cleared", int'(tsrL2), int'(5'b11000));

    // Randomized phase against the model
    for (int i = 0; i < 600; i++) begin
      resetCore = ($urandom_range(0, 149) == 0);
      if (i % 25 == 0) timerControlL2 = 10'($urandom);
      wdTap          = 4'($urandom);
      fitTap         = 4'($urandom);
      PCL_mtSPR      = ($urandom_range(0, 3) == 0);
      tsrDcd         = 1'($urandom_range(0, 1));
      PCL_sprHold    = ($urandom_range(0, 3) == 0);
      EXE_sprDataBus = 5'($urandom);
      cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/p405s_watchdogfitcontrol.md
Name: p405s_watchdogFitControl

Overview:
- Sequences the watchdog and fixed-interval timer (FIT) events configured by the timer control register (TCR[0:9]).
- Detects rising transitions on the selected time-base tap bits and advances the watchdog state machine.
- Maintains the watchdog/FIT timer status bits, including software write-one-to-clear.
- Generates the watchdog interrupt, the FIT interrupt and the timed watchdog reset request toward the reset logic.

Parameters:
- RST_CYCLES, 16, number of CB cycles the watchdog reset request is held asserted (range 1..255).

Ports:
- CB  input  1  core clock; all state updates on its rising edge.
- resetCore  input  1  synchronous, active-high reset.
- timerControlL2  input  10  TCR: [0:1] WP (watchdog period select), [2:3] WRC (watchdog reset control), [4] WIE, [5] DIE (unused here), [6:7] FP (FIT period select), [8] FIE, [9] ARE (unused here).
- wdTap  input  4  time-base bits used as watchdog period taps; index = WP.
- fitTap  input  4  time-base bits used as FIT period taps; index = FP.
- EXE_sprDataBus  input  5  mtSPR write data for the status register, same bit order as tsrL2.
- PCL_mtSPR  input  1  mtSPR in progress.
- PCL_sprHold  input  1  SPR write stalled.
- tsrDcd  input  1  SPR address decodes to the timer status register.
- tsrL2  output  5  status: [0] ENW, [1] WIS, [2:3] WRS, [4] FIS.
- wdInt  output  1  watchdog interrupt request = WIS & WIE.
- fitInt  output  1  FIT interrupt request = FIS & FIE.
- wdResetReq  output  2  reset type request (= WRS value); nonzero only while in RST state.

Behaviour:
- Reset (resetCore=1 at a CB edge):
  - tsrL2=0, state=IDLE, counter=0, wdResetReq=00.
  - wdTapQ<=wdTap and fitTapQ<=fitTap, so no event is detected in the first cycle after reset.
  - Reset overrides all other activity, including an active RST state.
- Tap capture: wdTapQ/fitTapQ register all 4 bits every cycle.
  - wdEvent = wdTap[WP] & ~wdTapQ[WP]; fitEvent = fitTap[FP] & ~fitTapQ[FP].
  - Changing WP/FP causes no false edge unless the newly selected bit itself rose.
- Software clear: clrEn = PCL_mtSPR & tsrDcd & ~PCL_sprHold.
  - When clrEn=1, each tsr bit with EXE_sprDataBus bit = 1 is cleared (write-one-to-clear).
  - Zero data bits leave the corresponding tsr bits unchanged. No software set path exists.
- Update order within one cycle: apply the clear first, then evaluate events on the post-clear values.
  - The set from an event wins over a clear of the same bit in the same cycle.
- FIT: fitEvent sets FIS (already 1 -> stays 1).
- Watchdog states: IDLE, RST.
  - IDLE, wdEvent, post-clear ENW=0 -> ENW<=1.
  - IDLE, wdEvent, ENW=1, WIS=0 -> WIS<=1.
  - IDLE, wdEvent, ENW=1, WIS=1, WRC=00 -> no change (stays IDLE).
  - IDLE, wdEvent, ENW=1, WIS=1, WRC!=00 -> WRS<=WRC, counter<=RST_CYCLES-1, state<=RST.
  - RST:
    - wdResetReq=WRS.
    - counter decrements each cycle; at 0 -> IDLE next cycle, so the request is held exactly RST_CYCLES cycles.
    - wdEvents are ignored; fitEvents and software clears still act.
    - Clearing WRS while in RST does not shorten the pulse; wdResetReq uses a registered copy captured on entry.
- WRS is sticky: it is cleared only by resetCore or by software write-one-to-clear.
- Interrupt outputs are combinational from registered tsr/TCR bits, with zero added latency. tsr changes are visible the cycle after the causing edge.

Test Plan:
- Reset with wdTap[0]=1 held, WP=00 -> no event in the following cycle; tsrL2=00000, wdResetReq=00.
- WP=01, WIE=1, WRC=10; three rising edges on wdTap[1] -> tsrL2 goes 10000 -> 11000 (wdInt=1) -> 11100. wdResetReq=10 for exactly 16 cycles, then 00; WRS remains 10.
- ENW=1, WIS=0; a wdEvent and an mtSPR clear with data 10000 in the same cycle (PCL_sprHold=0) -> ENW=1, WIS=0 afterwards. Same test with PCL_sprHold=1 -> WIS=1 (event advances; clear blocked).
- FP=11, FIE=1; fitTap[3] rises -> FIS=1, fitInt=1. Clear with data 00001 -> FIS=0. Toggling FP to select an already-high tap -> no event.
- ENW=WIS=1, WRC=00; wdEvent -> state unchanged, wdResetReq=00. Then set WRC=11 and issue a wdEvent -> wdResetReq=11. resetCore asserted mid-pulse -> all outputs 0 next cycle.
- In RST, a further wdTap edge and an mtSPR clear of WRS (data 00110) -> pulse length unchanged at RST_CYCLES; WRS reads 00 after the clear.
